// File: rtl/pkt_port_arbiter.sv
// Packet-atomic round-robin arbiter merging NumIn D/D_VALID/D_BP streams
// onto one router port; a granted packet always runs to completion.
module pkt_port_arbiter #(
  parameter int NumIn   = 4,
  parameter int Width   = 64,
  parameter int LenBits = 16,
  parameter int Timeout = 1023
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   HOLD,
  input  logic [NumIn*Width-1:0] D,
  input  logic [NumIn-1:0]       D_VALID,
  output logic [NumIn-1:0]       D_BP,
  output logic [Width-1:0]       Q,
  output logic                   Q_VALID,
  input  logic                   Q_BP,
  output logic                   Q_SOF,
  output logic [NumIn-1:0]       GRANT,
  output logic                   BUSY,
  output logic                   STALL
);

  localparam int PW = $clog2(NumIn);
  localparam int TW = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
  localparam logic [TW-1:0] TMax = TW'(Timeout);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAY
  } state_e;

  state_e             state_q, state_d;
  logic [NumIn-1:0]   grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [LenBits-1:0] cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               stall_q, stall_d;

  logic               busy;
  logic               xfer;
  logic [Width-1:0]   word;
  logic [LenBits-1:0] hdr_len;
  logic               pick_vld;
  logic [PW-1:0]      pick;

  // ptr_q doubles as the owner index while a packet is in flight
  assign busy    = (state_q != S_IDLE);
  assign word    = D[ptr_q*Width +: Width];
  assign hdr_len = word[LenBits-1:0];
  assign xfer    = busy & D_VALID[ptr_q] & ~Q_BP;

  assign Q       = busy ? word : '0;
  assign Q_VALID = busy & D_VALID[ptr_q];
  assign D_BP    = ~grant_q | {NumIn{Q_BP | ~busy}};
  assign Q_SOF   = (state_q == S_HDR) & xfer;
  assign GRANT   = grant_q;
  assign BUSY    = busy;
  assign STALL   = stall_q;

  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = ptr_q;
    for (int k = 1; k <= NumIn; k++) begin
      idx = (int'(ptr_q) + k) % NumIn;
      if (!pick_vld && D_VALID[idx]) begin
        pick_vld = 1'b1;
        pick     = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    stall_d = stall_q;
    unique case (state_q)
      S_IDLE: begin
        tmo_d   = '0;
        grant_d = '0;
        if (!HOLD && pick_vld) begin
          grant_d = NumIn'(1) << pick;
          ptr_d   = pick;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (xfer) begin
          cnt_d = hdr_len;
          if (hdr_len == '0) begin
            state_d = S_IDLE;
            grant_d = '0;
          end else begin
            state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (xfer) begin
          cnt_d = cnt_q - LenBits'(1);
          if (cnt_q == LenBits'(1)) begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    if (busy) begin
      if (xfer) begin
        tmo_d = '0;
      end else if (Timeout != 0 && tmo_q != TMax) begin
        tmo_d = tmo_q + TW'(1);
      end
      if (Timeout != 0 && tmo_d == TMax) begin
        stall_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NumIn - 1);
      cnt_q   <= '0;
      tmo_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      stall_q <= stall_d;
    end
  end

endmodule
